// File: rtl/pcap_dma_writer.sv
// Burst-write DMA stage: buffers captured words in a FWFT FIFO and writes them as AXI3 INCR bursts
// into double-buffered host blocks. Define PCAP_DMA_TIMEOUT_EN to enable the idle-flush timeout.
module pcap_dma_writer #(
    parameter int unsigned FIFO_AW        = 6,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        enable_i,
    input  logic [31:0] dma_addr_i,
    input  logic        dma_addr_wstb_i,
    input  logic [31:0] block_size_i,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    input  logic        capture_done_i,
    output logic        irq_o,
    output logic [3:0]  irq_status_o,
    output logic [31:0] m_axi_awaddr,
    output logic [3:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned CntW  = FIFO_AW + 1;

    if (BURST_LEN < 2 || BURST_LEN > 16 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("pcap_dma_writer: BURST_LEN must be 2..16 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StAw, StW, StB, StHalt} state_e;

    state_e             state_q;
    logic [31:0]        mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic               ready_q, enable_q, irq_q;
    logic [3:0]         status_q;
    logic [31:0]        cur_addr_q, next_addr_q, rem_q;
    logic               cur_valid_q, next_valid_q;
    logic               flush_q, flush_cap_q;
    logic [3:0]         awlen_q, beat_q;
    logic               push, pop, fifo_empty, go_burst, timeout_hit;
    logic [4:0]         burst_beats;
    logic [31:0]        beat_bytes, rem_words;

    assign fifo_empty   = (count_q == '0);
    assign push         = data_valid_i && ready_q;
    assign pop          = m_axi_wvalid && m_axi_wready;
    assign rem_words    = {2'b00, rem_q[31:2]};
    assign beat_bytes   = (32'(awlen_q) + 32'd1) << 2;
    assign go_burst     = cur_valid_q &&
                          ((count_q >= CntW'(BURST_LEN)) || (flush_q && !fifo_empty));

    assign data_ready_o  = ready_q;
    assign irq_o         = irq_q;
    assign irq_status_o  = status_q;
    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == StAw);
    assign m_axi_wvalid  = (state_q == StW) && !fifo_empty;
    assign m_axi_wdata   = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = m_axi_wvalid && (beat_q == awlen_q);
    assign m_axi_bready  = (state_q == StB);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Burst size is bounded by FIFO occupancy, full burst length and the block remainder.
    always_comb begin
        burst_beats = 5'(BURST_LEN);
        if (count_q < CntW'(BURST_LEN)) begin
            burst_beats = 5'(count_q);
        end
        if (rem_words < 32'(burst_beats)) begin
            burst_beats = rem_words[4:0];
        end
    end

`ifdef PCAP_DMA_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    assign timeout_hit = (idle_cnt_q >= TIMEOUT_CYCLES);
    always_ff @(posedge ACLK) begin
        if (!ARESETn || !enable_i || push || fifo_empty) begin
            idle_cnt_q <= '0;
        end else if (!timeout_hit) begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            enable_q     <= 1'b0;
            irq_q        <= 1'b0;
            status_q     <= '0;
            cur_addr_q   <= '0;
            next_addr_q  <= '0;
            rem_q        <= '0;
            cur_valid_q  <= 1'b0;
            next_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            flush_cap_q  <= 1'b0;
            awlen_q      <= '0;
            beat_q       <= '0;
        end else begin
            enable_q <= enable_i;
            irq_q    <= 1'b0;
            if (enable_i && !enable_q) begin
                status_q <= '0;
            end
            if (!enable_i) begin
                // Abandons any in-flight transaction; status stays for the host to read.
                state_q     <= StIdle;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                ready_q     <= 1'b0;
                cur_valid_q <= 1'b0;
                flush_q     <= 1'b0;
                flush_cap_q <= 1'b0;
                beat_q      <= '0;
                if (enable_q) begin
                    next_valid_q <= 1'b0;
                end
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
                end
                count_q <= count_d;
                ready_q <= (state_q != StHalt) && (count_d < CntW'(Depth));
                if (flush_q && fifo_empty && state_q == StIdle) begin
                    flush_q     <= 1'b0;
                    flush_cap_q <= 1'b0;
                end
                unique case (state_q)
                    StIdle: begin
                        if (!cur_valid_q) begin
                            if (next_valid_q) begin
                                state_q <= StLoad;
                            end else if (flush_q && !fifo_empty) begin
                                status_q[2] <= 1'b1;
                                irq_q       <= 1'b1;
                                ready_q     <= 1'b0;
                                state_q     <= StHalt;
                            end
                        end else if (go_burst) begin
                            awlen_q <= 4'(burst_beats - 5'd1);
                            state_q <= StAw;
                        end
                    end
                    StLoad: begin
                        cur_addr_q   <= next_addr_q;
                        rem_q        <= block_size_i;
                        cur_valid_q  <= 1'b1;
                        next_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                    StAw: begin
                        if (m_axi_awready) begin
                            beat_q  <= '0;
                            state_q <= StW;
                        end
                    end
                    StW: begin
                        if (pop) begin
                            beat_q <= beat_q + 4'd1;
                            if (m_axi_wlast) begin
                                state_q <= StB;
                            end
                        end
                    end
                    StB: begin
                        if (m_axi_bvalid) begin
                            if (m_axi_bresp != 2'b00) begin
                                status_q[3] <= 1'b1;
                                irq_q       <= 1'b1;
                                ready_q     <= 1'b0;
                                state_q     <= StHalt;
                            end else begin
                                cur_addr_q <= cur_addr_q + beat_bytes;
                                rem_q      <= rem_q - beat_bytes;
                                state_q    <= StIdle;
                                if (rem_q == beat_bytes) begin
                                    status_q[0] <= 1'b1;
                                    irq_q       <= 1'b1;
                                    cur_valid_q <= 1'b0;
                                    if (!next_valid_q && count_q >= CntW'(BURST_LEN)) begin
                                        status_q[2] <= 1'b1;
                                        ready_q     <= 1'b0;
                                        state_q     <= StHalt;
                                    end
                                end
                                if (flush_q && fifo_empty) begin
                                    flush_q     <= 1'b0;
                                    flush_cap_q <= 1'b0;
                                    if (flush_cap_q) begin
                                        status_q[1] <= 1'b1;
                                        irq_q       <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    StHalt: begin
                        ready_q <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
                // Timeout-forced flushes never report capture done.
                if (capture_done_i) begin
                    flush_q     <= 1'b1;
                    flush_cap_q <= 1'b1;
                end else if (timeout_hit) begin
                    flush_q <= 1'b1;
                end
            end
            if (dma_addr_wstb_i) begin
                next_addr_q  <= dma_addr_i;
                next_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcap_dma_writer.sv
// Scoreboard bench for pcap_dma_writer: stimulus queues expected AW/W/IRQ traffic, a monitor checks it.
`timescale 1ns/1ps
module tb_pcap_dma_writer;
    localparam int unsigned BurstLen = 16;
`ifdef PCAP_DMA_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 8;
`else
    localparam int unsigned TimeoutCycles = 1024;
`endif

    logic        ACLK, ARESETn, enable_i, dma_addr_wstb_i, data_valid_i, data_ready_o;
    logic [31:0] dma_addr_i, block_size_i, data_i;
    logic        capture_done_i, irq_o;
    logic [3:0]  irq_status_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata;
    logic [3:0]  m_axi_awlen, m_axi_wstrb;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst, m_axi_bresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;

    pcap_dma_writer #(
        .FIFO_AW       (6),
        .BURST_LEN     (BurstLen),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .enable_i       (enable_i),
        .dma_addr_i     (dma_addr_i),
        .dma_addr_wstb_i(dma_addr_wstb_i),
        .block_size_i   (block_size_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .data_ready_o   (data_ready_o),
        .capture_done_i (capture_done_i),
        .irq_o          (irq_o),
        .irq_status_o   (irq_status_o),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_aw [$];
    logic [32:0] exp_w [$];
    logic [3:0]  exp_irq [$];
    logic [1:0]  bresp_cfg = 2'b00;
    logic [35:0] mon_aw;
    logic [32:0] mon_w;
    logic [3:0]  mon_irq;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [35:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Monitor: every AW/W handshake and irq pulse is matched against the scoreboard.
    always @(negedge ACLK) begin
        if (ARESETn && m_axi_awvalid && m_axi_awready) begin
            if (exp_aw.size() == 0) begin
                unexpected("aw", {m_axi_awlen, m_axi_awaddr});
            end else begin
                mon_aw = exp_aw.pop_front();
                check("aw len/addr", {m_axi_awlen, m_axi_awaddr}, mon_aw);
            end
        end
        if (ARESETn && m_axi_wvalid && m_axi_wready) begin
            if (exp_w.size() == 0) begin
                unexpected("w", {3'b000, m_axi_wlast, m_axi_wdata});
            end else begin
                mon_w = exp_w.pop_front();
                check("w last/data", {3'b000, m_axi_wlast, m_axi_wdata}, {3'b000, mon_w});
            end
        end
        if (ARESETn && irq_o) begin
            if (exp_irq.size() == 0) begin
                unexpected("irq", 36'(irq_status_o));
            end else begin
                mon_irq = exp_irq.pop_front();
                check("irq status", 36'(irq_status_o), 36'(mon_irq));
            end
        end
    end

    // B responder: answer every bready with one bvalid beat carrying bresp_cfg.
    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        forever begin
            @(negedge ACLK);
            m_axi_bvalid = m_axi_bready;
            m_axi_bresp  = m_axi_bready ? bresp_cfg : 2'b00;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [31:0] d);
        int n;
        @(negedge ACLK);
        data_valid_i = 1'b1;
        data_i       = d;
        n = 0;
        while (!data_ready_o && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        if (!data_ready_o) begin
            unexpected("push ready timeout", 36'(d));
        end
        @(posedge ACLK);
        #1 data_valid_i = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_word(base + 32'(i));
        end
    endtask

    task automatic expect_burst(input logic [31:0] addr, input int beats, input logic [31:0] d0);
        exp_aw.push_back({4'(beats - 1), addr});
        for (int i = 0; i < beats; i++) begin
            exp_w.push_back({(i == beats - 1), d0 + 32'(i)});
        end
    endtask

    task automatic start_block(input logic [31:0] addr, input logic [31:0] size);
        @(posedge ACLK);
        #1;
        block_size_i    = size;
        dma_addr_i      = addr;
        dma_addr_wstb_i = 1'b1;
        @(posedge ACLK);
        #1 dma_addr_wstb_i = 1'b0;
    endtask

    task automatic pulse_capture_done();
        @(posedge ACLK);
        #1 capture_done_i = 1'b1;
        @(posedge ACLK);
        #1 capture_done_i = 1'b0;
    endtask

    task automatic set_wready(input logic v);
        @(posedge ACLK);
        #1 m_axi_wready = v;
    endtask

    task automatic restart();
        @(posedge ACLK);
        #1;
        enable_i     = 1'b0;
        bresp_cfg    = 2'b00;
        m_axi_wready = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 enable_i = 1'b1;
        @(posedge ACLK);
        #1 check("status cleared on enable", 36'(irq_status_o), 36'h0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_irq.size()) != 0 && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        check(name, 36'(exp_aw.size() + exp_w.size() + exp_irq.size()), 36'h0);
        repeat (6) @(negedge ACLK);
    endtask

    initial begin
        int   n;
        logic saw;
        ARESETn         = 1'b0;
        enable_i        = 1'b0;
        dma_addr_i      = '0;
        dma_addr_wstb_i = 1'b0;
        block_size_i    = '0;
        data_i          = '0;
        data_valid_i    = 1'b0;
        capture_done_i  = 1'b0;
        m_axi_awready   = 1'b1;
        m_axi_wready    = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst data_ready", 36'(data_ready_o), 36'h0);
        check("rst awvalid", 36'(m_axi_awvalid), 36'h0);
        check("rst wvalid", 36'(m_axi_wvalid), 36'h0);
        check("rst bready", 36'(m_axi_bready), 36'h0);
        check("rst wlast", 36'(m_axi_wlast), 36'h0);
        check("rst irq", 36'(irq_o), 36'h0);
        check("rst status", 36'(irq_status_o), 36'h0);
        check("rst awaddr", 36'(m_axi_awaddr), 36'h0);
        check("rst awlen", 36'(m_axi_awlen), 36'h0);
        check("rst wdata", 36'(m_axi_wdata), 36'h0);
        check("awsize/awburst/wstrb", {27'd0, m_axi_awsize, m_axi_awburst, m_axi_wstrb},
              {27'd0, 3'b010, 2'b01, 4'hF});
        @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // Two full bursts complete a 128-byte block.
        restart();
        start_block(32'h0010_0000, 32'd128);
        expect_burst(32'h0010_0000, 16, 32'h1100_0000);
        expect_burst(32'h0010_0040, 16, 32'h1100_0010);
        exp_irq.push_back(4'b0001);
        push_words(32'h1100_0000, 32);
        wait_drain("t1 drained");
        check("t1 status", 36'(irq_status_o), 36'h1);

        // Five words flushed by capture_done.
        restart();
        start_block(32'h0020_0000, 32'd64);
        expect_burst(32'h0020_0000, 5, 32'h2200_0000);
        exp_irq.push_back(4'b0010);
        push_words(32'h2200_0000, 5);
`ifndef PCAP_DMA_TIMEOUT_EN
        saw = 1'b0;
        repeat (20) begin
            @(negedge ACLK);
            if (m_axi_awvalid) saw = 1'b1;
        end
        check("t2 partial held without flush", 36'(saw), 36'h0);
`endif
        pulse_capture_done();
        wait_drain("t2 drained");
        check("t2 status", 36'(irq_status_o), 36'h2);

        // Back-pressure: FIFO fills to 64, then everything drains in order.
        restart();
        set_wready(1'b0);
        start_block(32'h0030_0000, 32'd512);
        for (int k = 0; k < 4; k++) begin
            expect_burst(32'h0030_0000 + 32'(k * 64), 16, 32'h3300_0000 + 32'(k * 16));
        end
        expect_burst(32'h0030_0100, 6, 32'h3300_0040);
        exp_irq.push_back(4'b0010);
        push_words(32'h3300_0000, 64);
        @(negedge ACLK);
        check("t3 ready low when full", 36'(data_ready_o), 36'h0);
        set_wready(1'b1);
        push_words(32'h3300_0040, 6);
        pulse_capture_done();
        wait_drain("t3 drained");
        check("t3 status", 36'(irq_status_o), 36'h2);

        // Underrun: block done, no next address, 16 words still queued.
        restart();
        set_wready(1'b0);
        start_block(32'h0050_0000, 32'd64);
        expect_burst(32'h0050_0000, 16, 32'h5500_0000);
        exp_irq.push_back(4'b0101);
        push_words(32'h5500_0000, 32);
        set_wready(1'b1);
        wait_drain("t4 drained");
        check("t4 status", 36'(irq_status_o), 36'h5);
        check("t4 halt ready", 36'(data_ready_o), 36'h0);
        check("t4 halt awvalid", 36'(m_axi_awvalid), 36'h0);

        // SLVERR on the first burst halts the block.
        restart();
        bresp_cfg = 2'b10;
        start_block(32'h0060_0000, 32'd128);
        expect_burst(32'h0060_0000, 16, 32'h6600_0000);
        exp_irq.push_back(4'b1000);
        push_words(32'h6600_0000, 16);
        wait_drain("t5 drained");
        check("t5 status", 36'(irq_status_o), 36'h8);
        check("t5 halt ready", 36'(data_ready_o), 36'h0);

`ifdef PCAP_DMA_TIMEOUT_EN
        // Idle timeout flushes three words without reporting capture done.
        restart();
        start_block(32'h0040_0000, 32'd64);
        expect_burst(32'h0040_0000, 3, 32'h4400_0000);
        push_words(32'h4400_0000, 3);
        n = 0;
        @(negedge ACLK);
        while (!m_axi_awvalid && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("t6 timeout delay in window", 36'(n >= 8 && n <= 14), 36'h1);
        wait_drain("t6 drained");
        check("t6 status", 36'(irq_status_o), 36'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
